// File: rtl/seq_classifier_if.sv
// Sample stream and classification result bundle for seq_classifier.
// The stimulus source uses the master modport and the classifier uses the slave modport.
interface seq_classifier_if;
    logic       restart;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic [7:0] cand_mask;
    logic       locked;
    logic [2:0] seq_id;
    logic       fail;
    logic [7:0] expect_data;
    logic [7:0] sample_count;

    modport master (
        output restart, sample_valid, sample_data,
        input  cand_mask, locked, seq_id, fail, expect_data, sample_count
    );

    modport slave (
        input  restart, sample_valid, sample_data,
        output cand_mask, locked, seq_id, fail, expect_data, sample_count
    );
endinterface

// File: rtl/seq_classifier.sv
// Identifies which of the eight generator sequences produced an 8-bit sample stream.
// After lock it keeps checking every element and flags the first divergence.
module seq_classifier #(
    parameter int MIN_SAMPLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    seq_classifier_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_LOCKED,
        S_FAIL
    } state_t;

    // Each field holds either the current element k of a sequence or the extra
    // recurrence state needed to produce element k+1.
    typedef struct packed {
        logic [7:0] sq;
        logic [7:0] sq_step;
        logic [7:0] pw3;
        logic [7:0] tri_x;
        logic [7:0] tri_step;
        logic [7:0] fib_a;
        logic [7:0] fib_b;
        logic [7:0] pell_a;
        logic [7:0] pell_b;
        logic [7:0] luc_a;
        logic [7:0] luc_b;
        logic [7:0] pad_a;
        logic [7:0] pad_b;
        logic [7:0] pad_c;
        logic [7:0] syl;
    } model_t;

    typedef logic [7:0][7:0] elem_vec_t;

    localparam model_t MODEL_RESET = '{
        sq:       8'd0,
        sq_step:  8'd1,
        pw3:      8'd1,
        tri_x:    8'd0,
        tri_step: 8'd1,
        fib_a:    8'd1,
        fib_b:    8'd1,
        pell_a:   8'd0,
        pell_b:   8'd1,
        luc_a:    8'd2,
        luc_b:    8'd1,
        pad_a:    8'd1,
        pad_b:    8'd1,
        pad_c:    8'd1,
        syl:      8'd2
    };

    localparam logic [7:0] MIN_COUNT = 8'(MIN_SAMPLES);

    function automatic elem_vec_t model_elems(input model_t m);
        elem_vec_t e;
        e[0] = m.sq;
        e[1] = m.pw3;
        e[2] = m.tri_x;
        e[3] = m.fib_a;
        e[4] = m.pell_a;
        e[5] = m.luc_a;
        e[6] = m.pad_a;
        e[7] = m.syl;
        return e;
    endfunction

    // All arithmetic stays 8 bits wide, so every recurrence wraps modulo 256.
    function automatic model_t model_step(input model_t m);
        model_t n;
        n          = m;
        n.sq       = m.sq + m.sq_step;
        n.sq_step  = m.sq_step + 8'd2;
        n.pw3      = m.pw3 + {m.pw3[6:0], 1'b0};
        n.tri_x    = m.tri_x + m.tri_step;
        n.tri_step = m.tri_step + 8'd1;
        n.fib_a    = m.fib_b;
        n.fib_b    = m.fib_a + m.fib_b;
        n.pell_a   = m.pell_b;
        n.pell_b   = {m.pell_b[6:0], 1'b0} + m.pell_a;
        n.luc_a    = m.luc_b;
        n.luc_b    = m.luc_a + m.luc_b;
        n.pad_a    = m.pad_b;
        n.pad_b    = m.pad_c;
        n.pad_c    = m.pad_a + m.pad_b;
        n.syl      = m.syl * (m.syl - 8'd1) + 8'd1;
        return n;
    endfunction

    state_t     state,       state_nxt;
    model_t     model,       model_nxt;
    logic [7:0] cand_mask,   cand_mask_nxt;
    logic       locked,      locked_nxt;
    logic [2:0] seq_id,      seq_id_nxt;
    logic       fail,        fail_nxt;
    logic [7:0] expect_data, expect_data_nxt;
    logic [7:0] count,       count_nxt;

    model_t     stepped;
    elem_vec_t  cur_elems;
    elem_vec_t  next_elems;
    logic [7:0] hit;
    logic [7:0] new_mask;
    logic [7:0] count_inc;
    logic       accept;
    logic       one_hot;
    logic [2:0] hit_idx;

    assign stepped    = model_step(model);
    assign cur_elems  = model_elems(model);
    assign next_elems = model_elems(stepped);
    assign accept     = bus.sample_valid && !bus.restart && (state != S_FAIL);
    assign new_mask   = cand_mask & hit;
    assign count_inc  = (count == 8'hFF) ? 8'hFF : count + 8'd1;
    assign one_hot    = (new_mask != 8'd0) && ((new_mask & (new_mask - 8'd1)) == 8'd0);

    // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = 0; i < 8; i++) begin
            hit[i] = (cur_elems[i] == bus.sample_data);
            if (new_mask[i]) hit_idx = 3'(i);
        end
    end

    always_comb begin
        state_nxt       = state;
        model_nxt       = model;
        cand_mask_nxt   = cand_mask;
        locked_nxt      = locked;
        seq_id_nxt      = seq_id;
        fail_nxt        = fail;
        expect_data_nxt = expect_data;
        count_nxt       = count;

        if (bus.restart) begin
            state_nxt       = S_IDLE;
            model_nxt       = MODEL_RESET;
            cand_mask_nxt   = 8'hFF;
            locked_nxt      = 1'b0;
            seq_id_nxt      = 3'd0;
            fail_nxt        = 1'b0;
            expect_data_nxt = 8'd0;
            count_nxt       = 8'd0;
        end else if (accept) begin
            model_nxt     = stepped;
            count_nxt     = count_inc;
            cand_mask_nxt = new_mask;
            unique case (state)
                S_IDLE: begin
                    if (new_mask == 8'd0) begin
                        state_nxt = S_FAIL;
                        fail_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (new_mask == 8'd0) begin
                        state_nxt = S_FAIL;
                        fail_nxt  = 1'b1;
                    end else if (one_hot && (count_inc >= MIN_COUNT)) begin
                        state_nxt       = S_LOCKED;
                        locked_nxt      = 1'b1;
                        seq_id_nxt      = hit_idx;
                        expect_data_nxt = next_elems[hit_idx];
                    end
                end
                S_LOCKED: begin
                    if (bus.sample_data == expect_data) begin
                        expect_data_nxt = next_elems[seq_id];
                    end else begin
                        state_nxt       = S_FAIL;
                        cand_mask_nxt   = 8'd0;
                        locked_nxt      = 1'b0;
                        seq_id_nxt      = 3'd0;
                        expect_data_nxt = 8'd0;
                        fail_nxt        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            model       <= MODEL_RESET;
            cand_mask   <= 8'hFF;
            locked      <= 1'b0;
            seq_id      <= 3'd0;
            fail        <= 1'b0;
            expect_data <= 8'd0;
            count       <= 8'd0;
        end else begin
            state       <= state_nxt;
            model       <= model_nxt;
            cand_mask   <= cand_mask_nxt;
            locked      <= locked_nxt;
            seq_id      <= seq_id_nxt;
            fail        <= fail_nxt;
            expect_data <= expect_data_nxt;
            count       <= count_nxt;
        end
    end

    assign bus.cand_mask    = cand_mask;
    assign bus.locked       = locked;
    assign bus.seq_id       = seq_id;
    assign bus.fail         = fail;
    assign bus.expect_data  = expect_data;
    assign bus.sample_count = count;

endmodule

// File: tb/tb_seq_classifier.sv
// Directed bench for seq_classifier with hand-computed expected outputs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_classifier;

    logic clk = 1'b0;
    logic reset;

    seq_classifier_if sc_if ();

    seq_classifier #(.MIN_SAMPLES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sc_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    byte unsigned pw3_seq [8] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81, 8'd243, 8'd217, 8'd139};
    byte unsigned pw3_exp [8] = '{8'd0, 8'd0, 8'd27, 8'd81, 8'd243, 8'd217, 8'd139, 8'd161};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    task automatic check_all(input string tag, input logic [7:0] mask, input logic lk,
                             input logic [2:0] id, input logic fl, input logic [7:0] exp_d,
                             input logic [7:0] cnt);
        check({tag, ".cand_mask"},    32'(sc_if.cand_mask),    32'(mask));
        check({tag, ".locked"},       32'(sc_if.locked),       32'(lk));
        check({tag, ".seq_id"},       32'(sc_if.seq_id),       32'(id));
        check({tag, ".fail"},         32'(sc_if.fail),         32'(fl));
        check({tag, ".expect_data"},  32'(sc_if.expect_data),  32'(exp_d));
        check({tag, ".sample_count"}, 32'(sc_if.sample_count), 32'(cnt));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send(input byte unsigned d);
        sc_if.sample_valid = 1'b1;
        sc_if.sample_data  = d;
        @(negedge clk);
        sc_if.sample_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic do_restart(input logic with_sample, input byte unsigned d);
        sc_if.restart      = 1'b1;
        sc_if.sample_valid = with_sample;
        sc_if.sample_data  = d;
        @(negedge clk);
        sc_if.restart      = 1'b0;
        sc_if.sample_valid = 1'b0;
    endtask

    initial begin
        sc_if.restart      = 1'b0;
        sc_if.sample_valid = 1'b0;
        sc_if.sample_data  = 8'd0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);

        // Squares, back to back
        send(8'd0);
        check_all("sq1", 8'h15, 1'b0, 3'd0, 1'b0, 8'd0, 8'd1);
        send(8'd1);
        check_all("sq2", 8'h15, 1'b0, 3'd0, 1'b0, 8'd0, 8'd2);
        send(8'd4);
        check_all("sq3", 8'h01, 1'b1, 3'd0, 1'b0, 8'd9, 8'd3);
        do_restart(1'b0, 8'd0);
        check_all("rst_after_sq", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);

        // Powers of 3 with idle gaps, including mod-256 wrap
        for (int i = 0; i < 8; i++) begin
            send(pw3_seq[i]);
            idle();
            check($sformatf("pw3.locked%0d", i), 32'(sc_if.locked), 32'(i >= 2));
            check($sformatf("pw3.fail%0d", i),   32'(sc_if.fail),   32'd0);
            if (i >= 2)
                check($sformatf("pw3.expect%0d", i), 32'(sc_if.expect_data), 32'(pw3_exp[i]));
        end
        check_all("pw3_end", 8'h02, 1'b1, 3'd1, 1'b0, 8'd161, 8'd8);
        do_restart(1'b0, 8'd0);

        // Sylvester: unique after two samples but lock waits for the third
        send(8'd2);
        check_all("syl1", 8'hA0, 1'b0, 3'd0, 1'b0, 8'd0, 8'd1);
        send(8'd3);
        check_all("syl2", 8'h80, 1'b0, 3'd0, 1'b0, 8'd0, 8'd2);
        send(8'd7);
        check_all("syl3", 8'h80, 1'b1, 3'd7, 1'b0, 8'd43, 8'd3);
        send(8'd43);
        send(8'd15);
        check_all("syl5", 8'h80, 1'b1, 3'd7, 1'b0, 8'd211, 8'd5);
        do_restart(1'b0, 8'd0);

        // Immediate fail, then a further sample is ignored
        send(8'd5);
        check_all("ifail1", 8'h00, 1'b0, 3'd0, 1'b1, 8'd0, 8'd1);
        send(8'd0);
        check_all("ifail2", 8'h00, 1'b0, 3'd0, 1'b1, 8'd0, 8'd1);
        do_restart(1'b0, 8'd0);
        check_all("rst_from_fail", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);

        // Fibonacci locks, then diverges
        send(8'd1);
        check_all("fib1", 8'h4A, 1'b0, 3'd0, 1'b0, 8'd0, 8'd1);
        send(8'd1);
        check_all("fib2", 8'h48, 1'b0, 3'd0, 1'b0, 8'd0, 8'd2);
        send(8'd2);
        check_all("fib3", 8'h08, 1'b1, 3'd3, 1'b0, 8'd3, 8'd3);
        send(8'd3);
        check_all("fib4", 8'h08, 1'b1, 3'd3, 1'b0, 8'd5, 8'd4);
        send(8'd6);
        check_all("fib_div", 8'h00, 1'b0, 3'd0, 1'b1, 8'd0, 8'd5);
        do_restart(1'b0, 8'd0);

        // Restart beats a simultaneous sample
        send(8'd2);
        send(8'd1);
        check_all("luc2", 8'h20, 1'b0, 3'd0, 1'b0, 8'd0, 8'd2);
        do_restart(1'b1, 8'd3);
        check_all("luc_restart", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
        send(8'd1);
        send(8'd1);
        check_all("pad2", 8'h48, 1'b0, 3'd0, 1'b0, 8'd0, 8'd2);
        send(8'd1);
        check_all("pad3", 8'h40, 1'b1, 3'd6, 1'b0, 8'd2, 8'd3);
        send(8'd2);
        check_all("pad4", 8'h40, 1'b1, 3'd6, 1'b0, 8'd2, 8'd4);

        // Asynchronous reset between clock edges, mid-lock
        reset = 1'b1;
        #1;
        check_all("async_rst", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all("post_rst", 8'hFF, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);
        send(8'd0);
        send(8'd1);
        send(8'd4);
        check_all("sq_after_rst", 8'h01, 1'b1, 3'd0, 1'b0, 8'd9, 8'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_classifier.md
# seq_classifier

Receive-side companion to the sequence generator. Samples a stream of 8-bit sequence elements and identifies which of the eight generator sequences produced it, reproducing each sequence's modulo-256 recurrence from its reset value. Once identified, it keeps checking every further element and flags the first divergence. It sits on the bench/loopback path fed from the generator output byte. Its `seq_id` uses the same 3-bit encoding as the generator's sequence select.

## Interface
Parameters:
- `MIN_SAMPLES`, default 3: minimum accepted samples before lock is allowed (legal range 1..255).

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `restart`, input, 1: synchronous clear back to the reset state.
- `sample_valid`, input, 1: `sample_data` holds one new element this cycle.
- `sample_data`, input, 8: observed sequence element.
- `cand_mask`, output, 8: bit i = sequence i still consistent with all samples so far.
- `locked`, output, 1: exactly one candidate remains and at least `MIN_SAMPLES` samples have been accepted.
- `seq_id`, output, 3: identified sequence while `locked` is high, else 0.
- `fail`, output, 1: no candidate remains, or a locked stream diverged.
- `expect_data`, output, 8: next expected element of `seq_id` while `locked` is high, else 0.
- `sample_count`, output, 8: accepted samples, saturating at 255.

## Operation
- Sequence encoding, with elements 0.. listed:
  - 0 squares: k² — 0,1,4,9,16…
  - 1 powers of 3: 1,3,9,27,81,243,217,139…
  - 2 triangular: 0,1,3,6,10…
  - 3 Fibonacci: 1,1,2,3,5…
  - 4 Pell: 0,1,2,5,12,29…
  - 5 Lucas: 2,1,3,4,7…
  - 6 Padovan: 1,1,1,2,2,3,4…
  - 7 Sylvester, x → x(x−1)+1: 2,3,7,43,15,211…
- All arithmetic is mod 256 (8-bit wrap), with the same recurrences and seeds as the generator.
- Eight model registers hold each sequence's expected element k. All models advance by one element on every accepted sample, whether or not that candidate is still live.
- A sample is accepted when `sample_valid`=1, `restart`=0 and state ≠ FAIL.
- Per accepted sample: hit[i] = (model_i == `sample_data`); `cand_mask` ← `cand_mask` & hit; `sample_count` increments.
- States:
  - IDLE: `sample_count`=0, mask FF. First accepted sample → TRACK, or → FAIL if the new mask is 0.
  - TRACK:
    - new mask = 0 → FAIL.
    - popcount(new mask)=1 and new count ≥ `MIN_SAMPLES` → LOCKED, with `seq_id` = index of the set bit.
    - otherwise stay in TRACK.
  - LOCKED: each accepted sample is compared against `expect_data`. A match keeps LOCKED; a mismatch → FAIL with `cand_mask` ← 0 and `locked` ← 0.
  - FAIL: `fail`=1 and samples are ignored. Leaves only on `reset` or `restart`.
- `restart` (any state) restores the reset values of all outputs and models. It takes priority over a simultaneous `sample_valid`; that sample is discarded.
- Reset values:
  - `cand_mask`=FF; `locked`=0; `seq_id`=0; `fail`=0; `expect_data`=0; `sample_count`=0; state IDLE.
  - Every model is at element 0.

## Timing
- Every output is a register. The effect of a sample presented at edge N is visible immediately after edge N, with no further pipeline.
- With default `MIN_SAMPLES`=3, the third matching sample of any sequence sets `locked` at that edge. All eight sequences are pairwise distinct within their first three elements.
- `expect_data` is updated at the same edge as `locked` and on every later accepted sample.
- Idle cycles (`sample_valid`=0) hold all state. Back-to-back valid cycles are fully supported.
- Asynchronous `reset` clears state immediately, including mid-stream and mid-lock. Release is synchronous to `clk`.

## Test plan
- Squares: feed 0,1,4 on consecutive cycles.
  - After the 2nd sample: `cand_mask`=0x15.
  - After the 3rd sample: `locked`=1, `seq_id`=0, `expect_data`=9.
- Powers of 3, wrap check: feed 1,3,9,27,81,243,217,139 with idle gaps between samples. Required: locked from the 3rd sample with `seq_id`=1, `fail` never set, `sample_count`=8.
- Sylvester: feed 2,3,7,43,15.
  - After the 2nd sample: `cand_mask`=0x80, but `locked` stays 0 (`MIN_SAMPLES` not yet met).
  - Lock at the 3rd sample; `expect_data`=211 after the 5th sample.
- Immediate fail: first sample is 5. Required: `cand_mask`=0, `fail`=1. A further sample 0 changes nothing.
- Locked divergence: Fibonacci 1,1,2,3 then 6. Required: `locked` drops, `fail`=1, `cand_mask`=0.
- Restart and async reset:
  - Lucas 2,1, then `restart` asserted together with `sample_valid` carrying 3. Required: all outputs return to reset values and the sample is ignored; then 1,1,1 locks Padovan (`seq_id`=6).
  - Asserting `reset` between clock edges clears all outputs immediately.
